// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor: receiver-side checker for a one-hot red/yellow/green lamp interface.
// It decodes the lamp lines to a 2-bit code, tracks dwell time, checks the phase order
// RED->GREEN->YELLOW->RED and the dwell limits, and reports sticky faults and clean cycles.
module traffic_lamp_monitor #(
    parameter int CNT_W   = 16,
    parameter int RED_MIN = 8,
    parameter int RED_MAX = 32,
    parameter int GRN_MIN = 8,
    parameter int GRN_MAX = 32,
    parameter int YEL_MIN = 2,
    parameter int YEL_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             clear_fault,
    output logic [1:0]       state_out,
    output logic             state_valid,
    output logic [CNT_W-1:0] dwell,
    output logic             cycle_done,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [7:0]       fault_count
);

    localparam logic [1:0] C_RED = 2'b00;
    localparam logic [1:0] C_YEL = 2'b01;
    localparam logic [1:0] C_GRN = 2'b10;
    localparam logic [1:0] C_INV = 2'b11;

    localparam logic [2:0] EV_NONE  = 3'd0;
    localparam logic [2:0] EV_COMBO = 3'd1;
    localparam logic [2:0] EV_ORDER = 3'd2;
    localparam logic [2:0] EV_SHORT = 3'd3;
    localparam logic [2:0] EV_LONG  = 3'd4;

    // SYNC: no valid phase seen yet; PARTIAL: first phase, entered mid-way; TRACK: fully checked.
    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        PARTIAL = 2'd1,
        TRACK   = 2'd2
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [1:0]       state_q, state_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             cycle_done_q, cycle_done_d;
    logic             fault_q, fault_d;
    logic [2:0]       fault_code_q, fault_code_d;
    logic [7:0]       fault_count_q, fault_count_d;
    // Set on a clean entry into RED while tracking; any fault event or resync clears it.
    logic             clean_q, clean_d;

    logic             changed;
    logic             both_valid;
    logic             legal_tr;
    logic             yel_to_red;
    logic [2:0]       event_code;

    function automatic logic [CNT_W-1:0] min_of(input logic [1:0] code);
        case (code)
            C_RED:   min_of = CNT_W'(RED_MIN);
            C_GRN:   min_of = CNT_W'(GRN_MIN);
            C_YEL:   min_of = CNT_W'(YEL_MIN);
            default: min_of = '0;
        endcase
    endfunction

    // Limit plus one: the dwell value on which the long-dwell event fires.
    function automatic logic [CNT_W-1:0] max_plus1_of(input logic [1:0] code);
        case (code)
            C_RED:   max_plus1_of = CNT_W'(RED_MAX + 1);
            C_GRN:   max_plus1_of = CNT_W'(GRN_MAX + 1);
            C_YEL:   max_plus1_of = CNT_W'(YEL_MAX + 1);
            default: max_plus1_of = '1;
        endcase
    endfunction

    // Decode the lamp lines and advance the dwell counter.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d = C_INV;
        case ({red, yellow, green})
            3'b100:  state_d = C_RED;
            3'b010:  state_d = C_YEL;
            3'b001:  state_d = C_GRN;
            default: state_d = C_INV;
        endcase
        valid_d = (state_d != C_INV);
        changed = (state_d != state_q);
        if (changed) begin
            dwell_d = CNT_W'(1);
        end else if (dwell_q == '1) begin
            dwell_d = dwell_q;
        end else begin
            dwell_d = dwell_q + CNT_W'(1);
        end
    end

    // Classify this cycle's fault event (lowest code wins) and detect the clean YELLOW->RED.
    always_comb begin
        both_valid = (state_q != C_INV) && (state_d != C_INV);
        legal_tr   = ((state_q == C_RED) && (state_d == C_GRN)) ||
                     ((state_q == C_GRN) && (state_d == C_YEL)) ||
                     ((state_q == C_YEL) && (state_d == C_RED));
        yel_to_red = (fsm_q == TRACK) && (state_q == C_YEL) && (state_d == C_RED);

        event_code = EV_NONE;
        if ((state_d == C_INV) && (state_q != C_INV)) begin
            event_code = EV_COMBO;
        end else if (both_valid && changed && (fsm_q != SYNC) && !legal_tr) begin
            event_code = EV_ORDER;
        end else if (both_valid && changed && (fsm_q == TRACK) && (dwell_q < min_of(state_q))) begin
            event_code = EV_SHORT;
        end else if ((state_d != C_INV) && !changed && (fsm_q != SYNC) &&
                     (dwell_d == max_plus1_of(state_d))) begin
            event_code = EV_LONG;
        end

        cycle_done_d = yel_to_red && clean_q && (event_code == EV_NONE);

        clean_d = clean_q;
        if ((event_code != EV_NONE) || (state_d == C_INV)) begin
            clean_d = 1'b0;
        end else if (yel_to_red) begin
            clean_d = 1'b1;
        end
    end

    // Phase-tracking FSM: resync on any invalid code, then one partial phase before full checks.
    always_comb begin
        fsm_d = fsm_q;
        if (state_d == C_INV) begin
            fsm_d = SYNC;
        end else begin
            case (fsm_q)
                SYNC:    fsm_d = PARTIAL;
                PARTIAL: if (changed) fsm_d = TRACK;
                TRACK:   fsm_d = TRACK;
                default: fsm_d = SYNC;
            endcase
        end
    end

    // Sticky fault flag and first-code capture; a same-cycle event beats clear_fault.
    always_comb begin
        fault_d       = fault_q;
        fault_code_d  = fault_code_q;
        fault_count_d = fault_count_q;
        if (clear_fault) begin
            fault_d      = 1'b0;
            fault_code_d = EV_NONE;
        end
        if (event_code != EV_NONE) begin
            if (fault_count_q != 8'hFF) begin
                fault_count_d = fault_count_q + 8'd1;
            end
            if (!fault_q || clear_fault) begin
                fault_d      = 1'b1;
                fault_code_d = event_code;
            end
        end
    end

    // State register for every flop in the block.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            fsm_q         <= SYNC;
            state_q       <= C_INV;
            valid_q       <= 1'b0;
            dwell_q       <= '0;
            cycle_done_q  <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= EV_NONE;
            fault_count_q <= 8'd0;
            clean_q       <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            state_q       <= state_d;
            valid_q       <= valid_d;
            dwell_q       <= dwell_d;
            cycle_done_q  <= cycle_done_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
            fault_count_q <= fault_count_d;
            clean_q       <= clean_d;
        end
    end

    assign state_out   = state_q;
    assign state_valid = valid_q;
    assign dwell       = dwell_q;
    assign cycle_done  = cycle_done_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;
    assign fault_count = fault_count_q;

endmodule
